// File: rtl/instr_queue.sv
// instr_queue: multi-lane circular FIFO between decode and backend.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   flush_in            : empties the queue; overflow flag survives
//   push_count_in/data  : up to INSTR_Q_WIDTH in-order uops, lane 0 oldest
//   pop_req_in          : entries the backend wants this cycle
//   pop_data/valid/count: oldest POP_WIDTH entries, valid mask, entries taken
//   free_slots/count_out: occupancy view; push_ready_out when a full push fits
//   overflow_err_out    : sticky, set by a rejected push
module instr_queue #(
   parameter int INSTR_Q_DEPTH = 16,
   parameter int INSTR_Q_WIDTH = 4,
   parameter int POP_WIDTH     = 4,
   parameter int UOP_W         = 32,
   localparam int PW = $clog2(INSTR_Q_WIDTH + 1),
   localparam int OW = $clog2(POP_WIDTH + 1),
   localparam int CW = $clog2(INSTR_Q_DEPTH + 1)
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                flush_in,
   input  logic [PW-1:0]                       push_count_in,
   input  logic [INSTR_Q_WIDTH-1:0][UOP_W-1:0] push_data_in,
   input  logic [OW-1:0]                       pop_req_in,
   output logic [POP_WIDTH-1:0][UOP_W-1:0]     pop_data_out,
   output logic [POP_WIDTH-1:0]                pop_valid_out,
   output logic [OW-1:0]                       pop_count_out,
   output logic [CW-1:0]                       free_slots_out,
   output logic                                push_ready_out,
   output logic [CW-1:0]                       count_out,
   output logic                                overflow_err_out
);
   localparam int AW = $clog2(INSTR_Q_DEPTH);
   logic [UOP_W-1:0] mem_q [INSTR_Q_DEPTH];
   logic [UOP_W-1:0] mem_d [INSTR_Q_DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, push_n, pop_n, free;
   logic ovf_q, ovf_d, accept;
   // Space is judged on start-of-cycle occupancy; same-cycle pops never make room.
   always_comb begin
      free   = CW'(INSTR_Q_DEPTH) - count_q;
      push_n = (push_count_in > PW'(INSTR_Q_WIDTH)) ? CW'(INSTR_Q_WIDTH) : CW'(push_count_in);
      accept = push_n <= free;
      pop_n  = (rst_in || flush_in) ? '0 : ((CW'(pop_req_in) < count_q) ? CW'(pop_req_in) : count_q);
   end
   assign free_slots_out   = free;
   assign push_ready_out   = free >= CW'(INSTR_Q_WIDTH);
   assign count_out        = count_q;
   assign overflow_err_out = ovf_q;
   assign pop_count_out    = OW'(pop_n);
   always_comb begin
      for (int i = 0; i < POP_WIDTH; i++) begin
         pop_data_out[i]  = mem_q[AW'(head_q + AW'(i))];
         pop_valid_out[i] = CW'(i) < count_q;
      end
   end
   // Pointer sums truncate to AW bits, which gives the modulo-depth wrap.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q;
      count_d = count_q - pop_n;
      ovf_d   = ovf_q;
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (accept) begin
         tail_d  = tail_q + AW'(push_n);
         count_d = count_q - pop_n + push_n;
         for (int k = 0; k < INSTR_Q_WIDTH; k++)
            if (CW'(k) < push_n) mem_d[AW'(tail_q + AW'(k))] = push_data_in[k];
      end else begin
         ovf_d = 1'b1;
      end
   end
   always_ff @(posedge clk_in) begin
      mem_q <= mem_d;
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed and randomized checks of instr_queue against a queue model.
module tb_instr_queue;
   localparam int D = 16, W = 4, P = 4, UW = 32;
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   logic rst_in, flush_in;
   logic [2:0] push_count_in, pop_req_in, pop_count_out;
   logic [W-1:0][UW-1:0] push_data_in;
   logic [P-1:0][UW-1:0] pop_data_out;
   logic [P-1:0] pop_valid_out;
   logic [4:0] free_slots_out, count_out;
   logic push_ready_out, overflow_err_out;
   int n_cmp = 0, n_bad = 0;
   logic [UW-1:0] mq[$];
   bit mo = 0;
   int seq = 0;

   instr_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
      .push_count_in(push_count_in), .push_data_in(push_data_in),
      .pop_req_in(pop_req_in), .pop_data_out(pop_data_out),
      .pop_valid_out(pop_valid_out), .pop_count_out(pop_count_out),
      .free_slots_out(free_slots_out), .push_ready_out(push_ready_out),
      .count_out(count_out), .overflow_err_out(overflow_err_out)
   );

   task automatic set_in(input bit r, input bit f, input int pc, input int pr);
      rst_in = r;
      flush_in = f;
      push_count_in = 3'(pc);
      pop_req_in = 3'(pr);
      for (int k = 0; k < W; k++) begin
         push_data_in[k] = 32'hC0DE_0000 + 32'(seq);
         seq++;
      end
   endtask

   // Model advance from the rules: pops take the oldest entries, a push is
   // all-or-nothing against start-of-cycle free space, flush/reset empty it.
   task automatic tick();
      int n, pn, fr;
      n  = (push_count_in > 3'(W)) ? W : int'(push_count_in);
      pn = (int'(pop_req_in) < mq.size()) ? int'(pop_req_in) : mq.size();
      fr = D - mq.size();
      if (rst_in) begin
         mq.delete();
         mo = 0;
      end else if (flush_in) begin
         mq.delete();
      end else begin
         repeat (pn) void'(mq.pop_front());
         if (n <= fr) for (int k = 0; k < n; k++) mq.push_back(push_data_in[k]);
         else mo = 1;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      set_in(1, 0, 3, 0);
      tick();
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count_out !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count_out); end
      n_cmp++; if (free_slots_out !== 5'd16) begin n_bad++; $display("FAIL reset_free got %0d want 16", free_slots_out); end
      n_cmp++; if (pop_valid_out !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got %b want 0000", pop_valid_out); end
      n_cmp++; if (overflow_err_out !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow_err_out); end
      n_cmp++; if (push_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", push_ready_out); end
      n_cmp++; if (pop_count_out !== 3'd0) begin n_bad++; $display("FAIL reset_popcnt got %0d want 0", pop_count_out); end
   endtask

   task automatic test_basic();
      logic [UW-1:0] a, b, c;
      set_in(0, 0, 3, 0);
      a = push_data_in[0];
      b = push_data_in[1];
      c = push_data_in[2];
      tick();
      set_in(0, 0, 0, 2);
      #1;
      n_cmp++; if (pop_valid_out !== 4'b0111) begin n_bad++; $display("FAIL basic_valid got %b want 0111", pop_valid_out); end
      n_cmp++; if (pop_data_out[0] !== a) begin n_bad++; $display("FAIL basic_lane0 got %h want %h", pop_data_out[0], a); end
      n_cmp++; if (pop_data_out[1] !== b) begin n_bad++; $display("FAIL basic_lane1 got %h want %h", pop_data_out[1], b); end
      n_cmp++; if (pop_data_out[2] !== c) begin n_bad++; $display("FAIL basic_lane2 got %h want %h", pop_data_out[2], c); end
      n_cmp++; if (pop_count_out !== 3'd2) begin n_bad++; $display("FAIL basic_popcnt got %0d want 2", pop_count_out); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count_out !== 5'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", count_out); end
      n_cmp++; if (pop_data_out[0] !== c) begin n_bad++; $display("FAIL basic_lane0_after got %h want %h", pop_data_out[0], c); end
      set_in(0, 0, 0, 1);
      tick();
   endtask

   task automatic test_wrap();
      set_in(0, 0, 4, 0);
      tick();
      for (int c = 0; c < 6; c++) begin
         set_in(0, 0, 4, 4);
         #1;
         n_cmp++; if (count_out !== 5'd4) begin n_bad++; $display("FAIL wrap_count cycle %0d got %0d want 4", c, count_out); end
         n_cmp++; if (pop_count_out !== 3'd4) begin n_bad++; $display("FAIL wrap_popcnt cycle %0d got %0d want 4", c, pop_count_out); end
         for (int i = 0; i < P; i++) begin
            n_cmp++; if (pop_data_out[i] !== mq[i]) begin n_bad++; $display("FAIL wrap_lane%0d cycle %0d got %h want %h", i, c, pop_data_out[i], mq[i]); end
         end
         tick();
      end
      set_in(0, 0, 0, 4);
      tick();
   endtask

   task automatic test_overflow();
      for (int c = 0; c < 4; c++) begin
         set_in(0, 0, (c == 3) ? 2 : 4, 0);
         tick();
      end
      set_in(0, 0, 3, 4);
      #1;
      n_cmp++; if (count_out !== 5'd14) begin n_bad++; $display("FAIL ovf_fill got %0d want 14", count_out); end
      n_cmp++; if (pop_count_out !== 3'd4) begin n_bad++; $display("FAIL ovf_popcnt got %0d want 4", pop_count_out); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count_out !== 5'd10) begin n_bad++; $display("FAIL ovf_count got %0d want 10", count_out); end
      n_cmp++; if (overflow_err_out !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow_err_out); end
      n_cmp++; if (pop_data_out[0] !== mq[0]) begin n_bad++; $display("FAIL ovf_head got %h want %h", pop_data_out[0], mq[0]); end
      set_in(0, 1, 0, 0);
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (overflow_err_out !== 1'b1) begin n_bad++; $display("FAIL ovf_after_flush got %b want 1", overflow_err_out); end
      n_cmp++; if (count_out !== 5'd0) begin n_bad++; $display("FAIL ovf_flush_count got %0d want 0", count_out); end
   endtask

   task automatic test_full_pop();
      set_in(1, 0, 0, 0);
      tick();
      for (int c = 0; c < 4; c++) begin
         set_in(0, 0, 4, 0);
         tick();
      end
      set_in(0, 0, 0, 4);
      #1;
      n_cmp++; if (count_out !== 5'd16) begin n_bad++; $display("FAIL full_count got %0d want 16", count_out); end
      n_cmp++; if (push_ready_out !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", push_ready_out); end
      n_cmp++; if (free_slots_out !== 5'd0) begin n_bad++; $display("FAIL full_free got %0d want 0", free_slots_out); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count_out !== 5'd12) begin n_bad++; $display("FAIL full_pop_count got %0d want 12", count_out); end
      n_cmp++; if (push_ready_out !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready got %b want 1", push_ready_out); end
      n_cmp++; if (overflow_err_out !== 1'b0) begin n_bad++; $display("FAIL full_noerr got %b want 0", overflow_err_out); end
   endtask

   task automatic test_flush();
      logic [UW-1:0] x;
      set_in(1, 0, 0, 0);
      tick();
      set_in(0, 0, 4, 0);
      tick();
      set_in(0, 0, 3, 0);
      tick();
      set_in(0, 1, 2, 3);
      #1;
      n_cmp++; if (count_out !== 5'd7) begin n_bad++; $display("FAIL flush_pre_count got %0d want 7", count_out); end
      n_cmp++; if (pop_count_out !== 3'd0) begin n_bad++; $display("FAIL flush_popcnt got %0d want 0", pop_count_out); end
      tick();
      set_in(0, 0, 1, 0);
      x = push_data_in[0];
      #1;
      n_cmp++; if (count_out !== 5'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count_out); end
      n_cmp++; if (pop_valid_out !== 4'b0000) begin n_bad++; $display("FAIL flush_valid got %b want 0000", pop_valid_out); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (pop_valid_out !== 4'b0001) begin n_bad++; $display("FAIL flush_repush_valid got %b want 0001", pop_valid_out); end
      n_cmp++; if (pop_data_out[0] !== x) begin n_bad++; $display("FAIL flush_repush_lane0 got %h want %h", pop_data_out[0], x); end
   endtask

   task automatic test_empty_pop();
      logic [UW-1:0] x;
      set_in(1, 0, 0, 0);
      tick();
      set_in(0, 0, 2, 4);
      x = push_data_in[0];
      #1;
      n_cmp++; if (pop_count_out !== 3'd0) begin n_bad++; $display("FAIL empty_popcnt got %0d want 0", pop_count_out); end
      n_cmp++; if (pop_valid_out !== 4'b0000) begin n_bad++; $display("FAIL empty_valid got %b want 0000", pop_valid_out); end
      tick();
      set_in(0, 0, 0, 0);
      #1;
      n_cmp++; if (count_out !== 5'd2) begin n_bad++; $display("FAIL empty_count got %0d want 2", count_out); end
      n_cmp++; if (pop_data_out[0] !== x) begin n_bad++; $display("FAIL empty_lane0 got %h want %h", pop_data_out[0], x); end
   endtask

   task automatic test_random();
      int sz, pn;
      logic [P-1:0] ev;
      for (int c = 0; c < 400; c++) begin
         set_in($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 7), $urandom_range(0, 4));
         #1;
         sz = mq.size();
         pn = (rst_in || flush_in) ? 0 : ((int'(pop_req_in) < sz) ? int'(pop_req_in) : sz);
         for (int i = 0; i < P; i++) ev[i] = i < sz;
         n_cmp++; if (count_out !== 5'(sz)) begin n_bad++; $display("FAIL rnd_count cycle %0d got %0d want %0d", c, count_out, sz); end
         n_cmp++; if (free_slots_out !== 5'(D - sz)) begin n_bad++; $display("FAIL rnd_free cycle %0d got %0d want %0d", c, free_slots_out, D - sz); end
         n_cmp++; if (push_ready_out !== (D - sz >= W)) begin n_bad++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, push_ready_out, D - sz >= W); end
         n_cmp++; if (pop_valid_out !== ev) begin n_bad++; $display("FAIL rnd_valid cycle %0d got %b want %b", c, pop_valid_out, ev); end
         n_cmp++; if (pop_count_out !== 3'(pn)) begin n_bad++; $display("FAIL rnd_popcnt cycle %0d got %0d want %0d", c, pop_count_out, pn); end
         n_cmp++; if (overflow_err_out !== mo) begin n_bad++; $display("FAIL rnd_ovf cycle %0d got %b want %b", c, overflow_err_out, mo); end
         for (int i = 0; i < P; i++)
            if (i < sz) begin
               n_cmp++; if (pop_data_out[i] !== mq[i]) begin n_bad++; $display("FAIL rnd_lane%0d cycle %0d got %h want %h", i, c, pop_data_out[i], mq[i]); end
            end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_overflow();
      test_full_pop();
      test_flush();
      test_empty_pop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
